wb_arb2_timeout: RTL and testbench

//  Two-master to one-slave Wishbone classic arbiter that sits directly downstream of the dinofly core.

---
 rtl/wb_arb2_timeout.sv | 153 +++++++++++++++
 tb/tb_wb_arb2_timeout.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_arb2_timeout.sv
// Two-master (ibus/dbus) to one-slave Wishbone classic arbiter.
// Round-robin grant held for the whole CYC, plus a bus watchdog.
//
// Ports:
//   clk, rst_n            clock, async active-low reset
//   i_cyc/stb/we/adr      ibus request     -> i_ack, i_dat_r
//   d_cyc/stb/we/sel/adr  dbus request,
//   d_dat_w               dbus write data  -> d_ack, d_dat_r
//   m_cyc/stb/we/sel/adr  slave-side request
//   m_dat_w               slave-side write data
//   m_ack, m_dat_r        slave response
//   to_flag               sticky: a watchdog timeout has occurred
//   to_adr                m_adr captured at the latest timeout
module wb_arb2_timeout #(
  parameter int          TIMEOUT  = 255,
  parameter int          TO_W     = 8,
  parameter logic [31:0] ERR_DATA = 32'hDEAD_BEEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_cyc,
  input  logic        i_stb,
  input  logic        i_we,
  input  logic [29:0] i_adr,
  output logic        i_ack,
  output logic [31:0] i_dat_r,
  input  logic        d_cyc,
  input  logic        d_stb,
  input  logic        d_we,
  input  logic [3:0]  d_sel,
  input  logic [29:0] d_adr,
  input  logic [31:0] d_dat_w,
  output logic        d_ack,
  output logic [31:0] d_dat_r,
  output logic        m_cyc,
  output logic        m_stb,
  output logic        m_we,
  output logic [3:0]  m_sel,
  output logic [29:0] m_adr,
  output logic [31:0] m_dat_w,
  input  logic        m_ack,
  input  logic [31:0] m_dat_r,
  output logic        to_flag,
  output logic [29:0] to_adr
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GI   = 2'd1,
    GD   = 2'd2
  } state_t;

  localparam logic [TO_W-1:0] TO_LIM = TO_W'(TIMEOUT);

  state_t          state, state_nx;
  logic            last, last_nx;
  logic [TO_W-1:0] cnt, cnt_nx;
  logic            req;
  logic            hit;
  logic            gnt;
  logic            rd_sel;
  logic [31:0]     rd_dat;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      last    <= 1'b0;
      cnt     <= '0;
      to_flag <= 1'b0;
      to_adr  <= '0;
    end else begin
      state <= state_nx;
      last  <= last_nx;
      cnt   <= cnt_nx;
      if (hit) begin
        to_flag <= 1'b1;
        to_adr  <= m_adr;
      end
    end
  end

  // Slave-side mux. Outputs derive from the registered state,
  // so an async reset clears them immediately.
  always_comb begin
    m_cyc   = 1'b0;
    m_we    = 1'b0;
    m_sel   = 4'h0;
    m_adr   = '0;
    m_dat_w = '0;
    req     = 1'b0;
    unique case (state)
      GI: begin
        m_cyc = i_cyc;
        req   = i_cyc & i_stb;
        m_we  = i_we;
        m_sel = 4'hF;
        m_adr = i_adr;
      end
      GD: begin
        m_cyc   = d_cyc;
        req     = d_cyc & d_stb;
        m_we    = d_we;
        m_sel   = d_sel;
        m_adr   = d_adr;
        m_dat_w = d_dat_w;
      end
      default: ;
    endcase
    // A real ack in the expiry cycle takes precedence.
    hit   = req & ~m_ack & (cnt == TO_LIM);
    m_stb = req & ~hit;
  end

  assign gnt    = (state != IDLE);
  assign rd_dat = hit ? ERR_DATA : m_dat_r;
  assign rd_sel = (state == GD);

  assign i_ack   = gnt & ~rd_sel & (m_ack | hit);
  assign i_dat_r = (state == GI) ? rd_dat : '0;
  assign d_ack   = rd_sel & (m_ack | hit);
  assign d_dat_r = rd_sel ? rd_dat : '0;

  assign cnt_nx = (gnt & m_stb & ~m_ack) ? cnt + 1'b1 : '0;

  // last: 0 = ibus, 1 = dbus
  always_comb begin
    state_nx = state;
    last_nx  = last;
    unique case (state)
      IDLE: begin
        unique case (1'b1)
          (i_cyc & d_cyc): begin
            state_nx = last ? GI : GD;
            last_nx  = ~last;
          end
          (i_cyc & ~d_cyc): begin
            state_nx = GI;
            last_nx  = 1'b0;
          end
          (~i_cyc & d_cyc): begin
            state_nx = GD;
            last_nx  = 1'b1;
          end
          default: ;
        endcase
      end
      GI: if (!i_cyc) state_nx = IDLE;
      GD: if (!d_cyc) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

endmodule

// File: tb/tb_wb_arb2_timeout.sv
// Bench for wb_arb2_timeout: directed scenarios plus random
// traffic, checked every cycle against a transaction-level model.
module tb_wb_arb2_timeout;

  localparam int          TMO = 4;
  localparam logic [31:0] ERR = 32'hDEAD_BEEF;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_cyc, i_stb, i_we;
  logic [29:0] i_adr;
  logic        i_ack;
  logic [31:0] i_dat_r;
  logic        d_cyc, d_stb, d_we;
  logic [3:0]  d_sel;
  logic [29:0] d_adr;
  logic [31:0] d_dat_w;
  logic        d_ack;
  logic [31:0] d_dat_r;
  logic        m_cyc, m_stb, m_we;
  logic [3:0]  m_sel;
  logic [29:0] m_adr;
  logic [31:0] m_dat_w;
  logic        m_ack;
  logic [31:0] m_dat_r;
  logic        to_flag;
  logic [29:0] to_adr;

  int n_chk = 0;
  int n_err = 0;

  wb_arb2_timeout #(
    .TIMEOUT (TMO),
    .TO_W    (8),
    .ERR_DATA(ERR)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_cyc  (i_cyc),
    .i_stb  (i_stb),
    .i_we   (i_we),
    .i_adr  (i_adr),
    .i_ack  (i_ack),
    .i_dat_r(i_dat_r),
    .d_cyc  (d_cyc),
    .d_stb  (d_stb),
    .d_we   (d_we),
    .d_sel  (d_sel),
    .d_adr  (d_adr),
    .d_dat_w(d_dat_w),
    .d_ack  (d_ack),
    .d_dat_r(d_dat_r),
    .m_cyc  (m_cyc),
    .m_stb  (m_stb),
    .m_we   (m_we),
    .m_sel  (m_sel),
    .m_adr  (m_adr),
    .m_dat_w(m_dat_w),
    .m_ack  (m_ack),
    .m_dat_r(m_dat_r),
    .to_flag(to_flag),
    .to_adr (to_adr)
  );

  always #5 clk = ~clk;

  task automatic check(string tag, logic [63:0] got,
                       logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h t=%0t",
               tag, got, exp, $time);
    end
  endtask

  // Model: who owns the bus (0 none, 1 ibus, 2 dbus), who
  // owned it last, how long the current strobe has waited.
  int          own, lst, age;
  bit          flg;
  logic [29:0] tad;
  int          own_n, lst_n, age_n;
  bit          flg_n;
  logic [29:0] tad_n;

  task automatic mdl_reset();
    own = 0; lst = 1; age = 0; flg = 0; tad = '0;
  endtask

  task automatic model_check();
    bit          cyc, req, hit;
    logic        e_cyc, e_stb, e_we, e_iack, e_dack;
    logic [3:0]  e_sel;
    logic [29:0] e_adr;
    logic [31:0] e_dw, e_idat, e_ddat;
    cyc = 0; req = 0; hit = 0;
    e_cyc = 0; e_stb = 0; e_we = 0; e_sel = 0; e_adr = 0;
    e_dw = 0; e_iack = 0; e_dack = 0; e_idat = 0; e_ddat = 0;
    if (own == 1) begin
      cyc = i_cyc; req = i_cyc && i_stb;
      hit = req && !m_ack && age == TMO;
      e_we = i_we; e_sel = 4'hF; e_adr = i_adr;
      e_iack = m_ack || hit;
      e_idat = hit ? ERR : m_dat_r;
    end else if (own == 2) begin
      cyc = d_cyc; req = d_cyc && d_stb;
      hit = req && !m_ack && age == TMO;
      e_we = d_we; e_sel = d_sel; e_adr = d_adr; e_dw = d_dat_w;
      e_dack = m_ack || hit;
      e_ddat = hit ? ERR : m_dat_r;
    end
    e_cyc = cyc;
    e_stb = req && !hit;
    check("m_cyc", m_cyc, e_cyc);
    check("m_stb", m_stb, e_stb);
    check("m_we", m_we, e_we);
    check("m_sel", m_sel, e_sel);
    check("m_adr", m_adr, e_adr);
    check("m_dat_w", m_dat_w, e_dw);
    check("i_ack", i_ack, e_iack);
    check("i_dat_r", i_dat_r, e_idat);
    check("d_ack", d_ack, e_dack);
    check("d_dat_r", d_dat_r, e_ddat);
    check("to_flag", to_flag, flg);
    check("to_adr", to_adr, tad);
    lst_n = lst; flg_n = flg; tad_n = tad;
    if (own == 0) begin
      if (i_cyc && d_cyc) own_n = (lst == 1) ? 2 : 1;
      else if (i_cyc)     own_n = 1;
      else if (d_cyc)     own_n = 2;
      else                own_n = 0;
      if (own_n != 0) lst_n = own_n;
    end else begin
      own_n = cyc ? own : 0;
    end
    age_n = (req && !m_ack && !hit) ? age + 1 : 0;
    if (hit) begin
      flg_n = 1;
      tad_n = e_adr;
    end
  endtask

  task automatic tick();
    #1;
    model_check();
    @(posedge clk);
    if (!rst_n) mdl_reset();
    else begin
      own = own_n; lst = lst_n; age = age_n;
      flg = flg_n; tad = tad_n;
    end
    #1;
  endtask

  task automatic idle_inputs();
    i_cyc = 0; i_stb = 0; i_we = 0; i_adr = 0;
    d_cyc = 0; d_stb = 0; d_we = 0; d_sel = 0; d_adr = 0;
    d_dat_w = 0; m_ack = 0; m_dat_r = 0;
  endtask

  task automatic do_reset();
    rst_n = 0;
    idle_inputs();
    mdl_reset();
    @(posedge clk);
    #1;
    rst_n = 1;
  endtask

  int ack_pct;

  initial begin
    rst_n = 0;
    idle_inputs();
    mdl_reset();
    #2;
    check("rst_m_cyc", m_cyc, 0);
    check("rst_m_stb", m_stb, 0);
    check("rst_acks", {i_ack, d_ack}, 0);
    check("rst_flag", to_flag, 0);
    @(posedge clk);
    #1;
    rst_n = 1;

    // 1: lone dbus request, slave acks after 2 cycles
    d_cyc = 1; d_stb = 1; d_adr = 30'h100; d_sel = 4'h3;
    #1 check("t1_idle", m_cyc, 0);
    tick();
    #1 check("t1_cyc", m_cyc, 1);
    check("t1_adr", m_adr, 30'h100);
    tick();
    tick();
    m_ack = 1; m_dat_r = 32'h1234_5678;
    #1 check("t1_dack", d_ack, 1);
    check("t1_ddat", d_dat_r, 32'h1234_5678);
    check("t1_iack", i_ack, 0);
    tick();
    idle_inputs();
    tick();
    tick();

    // 2: both request; order D,I,D,I with a dead cycle between
    do_reset();
    i_cyc = 1; d_cyc = 1; i_adr = 30'h111; d_adr = 30'h222;
    tick();
    for (int g = 0; g < 4; g++) begin
      #1 check("t2_grant", m_cyc, 1);
      check("t2_order", m_adr, (g % 2) ? 30'h111 : 30'h222);
      tick();
      tick();
      if (g % 2) i_cyc = 0;
      else d_cyc = 0;
      tick();
      i_cyc = 1; d_cyc = 1;
      #1 check("t2_dead", m_cyc, 0);
      tick();
    end
    idle_inputs();
    tick();
    tick();

    // 3: ibus waits while dbus owns the bus
    do_reset();
    d_cyc = 1; d_adr = 30'h222;
    tick();
    i_cyc = 1; i_stb = 1; i_adr = 30'h40;
    m_ack = 1; m_dat_r = 32'hAAAA_5555;
    for (int k = 0; k < 3; k++) begin
      #1 check("t3_iwait", i_ack, 0);
      check("t3_adr_ne", m_adr != 30'h40, 1);
      tick();
    end
    d_cyc = 0; m_ack = 0;
    tick();
    tick();
    m_ack = 1; m_dat_r = 32'hC0DE_0040;
    #1 check("t3_adr", m_adr, 30'h40);
    check("t3_iack", i_ack, 1);
    check("t3_idat", i_dat_r, 32'hC0DE_0040);
    tick();
    idle_inputs();
    tick();
    tick();

    // 4: slave never acks; synthetic ack after TMO cycles
    do_reset();
    d_cyc = 1; d_stb = 1; d_adr = 30'h3FF;
    tick();
    for (int k = 0; k < TMO; k++) begin
      #1 check("t4_wait", d_ack, 0);
      check("t4_stb", m_stb, 1);
      tick();
    end
    #1 check("t4_dack", d_ack, 1);
    check("t4_ddat", d_dat_r, ERR);
    check("t4_stb0", m_stb, 0);
    check("t4_cyc1", m_cyc, 1);
    tick();
    #1 check("t4_flag", to_flag, 1);
    check("t4_tadr", to_adr, 30'h3FF);

    // 6: reset in the middle of a granted write
    d_we = 1; d_dat_w = 32'h5A5A_0001; d_adr = 30'h77;
    tick();
    m_ack = 1;
    #2;
    rst_n = 0;
    mdl_reset();
    #1 check("t6_cyc", m_cyc, 0);
    check("t6_stb", m_stb, 0);
    check("t6_dack", d_ack, 0);
    check("t6_iack", i_ack, 0);
    check("t6_flag", to_flag, 0);
    check("t6_tadr", to_adr, 0);
    @(posedge clk);
    #1;
    rst_n = 1;
    m_ack = 0;
    #1 check("t6_idle", m_cyc, 0);
    tick();
    idle_inputs();
    tick();
    tick();

    // 5: real ack in the expiry cycle wins
    do_reset();
    d_cyc = 1; d_stb = 1; d_adr = 30'h155;
    tick();
    for (int k = 0; k < TMO; k++) tick();
    m_ack = 1; m_dat_r = 32'h600D_F00D;
    #1 check("t5_dack", d_ack, 1);
    check("t5_ddat", d_dat_r, 32'h600D_F00D);
    tick();
    #1 check("t5_flag", to_flag, 0);
    idle_inputs();
    tick();
    tick();

    // Random traffic against the model
    do_reset();
    ack_pct = 30;
    for (int c = 0; c < 3000; c++) begin
      if (c % 250 == 0) begin
        case ($urandom_range(2))
          0: ack_pct = 0;
          1: ack_pct = 15;
          default: ack_pct = 60;
        endcase
      end
      if ($urandom_range(7) == 0) i_cyc = ~i_cyc;
      if ($urandom_range(7) == 0) d_cyc = ~d_cyc;
      i_stb   = ($urandom_range(3) != 0);
      d_stb   = ($urandom_range(3) != 0);
      i_we    = 1'($urandom);
      d_we    = 1'($urandom);
      d_sel   = 4'($urandom);
      i_adr   = 30'($urandom);
      d_adr   = 30'($urandom);
      d_dat_w = $urandom;
      m_ack   = ($urandom_range(99) < ack_pct);
      m_dat_r = $urandom;
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

endmodule
